// File: rtl/ffxkvar_dly.sv
// Run-time programmable multi-bit delay line with valid tag, clock enable and
// output blanking while the line refills after a delay change.
//
// Ports:
//   clk    : system clock, posedge
//   rst    : asynchronous reset, active-high
//   ce     : shift enable; 0 holds the whole line
//   dly    : requested delay in ce cycles (clamped to 1..DMAX)
//   idat   : input data
//   ivld   : input valid tag
//   odat   : delayed data, RSTVAL whenever ovld=0
//   ovld   : delayed valid, blanked while settling
//   settle : 1 while refilling after a delay change
module ffxkvar_dly #(
    parameter int              WID    = 8,
    parameter int              DMAX   = 16,
    parameter int              DW     = 5,
    parameter logic [WID-1:0]  RSTVAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic [DW-1:0]  dly,
    input  logic [WID-1:0] idat,
    input  logic           ivld,
    output logic [WID-1:0] odat,
    output logic           ovld,
    output logic           settle
);

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [DW:0] DMAX_X = (DW+1)'(DMAX);

    logic [WID-1:0] dat_q [DMAX];
    logic [DMAX-1:0] vld_q;

    logic [DW-1:0] dly_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic [DW-1:0] d_eff;
    logic [DW:0]   dly_x;
    state_t        st_q;
    state_t        st_d;
    logic          chg;

    logic [WID-1:0] tap_dat;
    logic           tap_vld;

    // Clamp in DW+1 bits so a large dly never wraps past DMAX.
    always_comb begin
        dly_x = {1'b0, dly};
        if (dly == '0)
            d_eff = DW'(1);
        else if (dly_x > DMAX_X)
            d_eff = DW'(DMAX);
        else
            d_eff = dly;
    end

    assign chg = (d_eff != dly_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DMAX; i++)
                dat_q[i] <= RSTVAL;
        end else if (ce) begin
            dat_q[0] <= idat;
            vld_q    <= {vld_q[DMAX-2:0], ivld};
            for (int i = 1; i < DMAX; i++)
                dat_q[i] <= dat_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= RUN;
            cnt_q <= '0;
            dly_q <= DW'(1);
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            if (chg)
                dly_q <= d_eff;
        end
    end

    // A change always wins: it restarts the refill count even mid-settle,
    // and a shift on the same edge is not counted toward the refill.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        priority case (1'b1)
            chg: begin
                st_d  = SETTLE;
                cnt_d = d_eff;
            end
            (st_q == SETTLE) && ce: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == DW'(1))
                    st_d = RUN;
            end
            default: ;
        endcase
    end

    always_comb begin
        tap_dat = dat_q[0];
        tap_vld = vld_q[0];
        for (int i = 0; i < DMAX; i++) begin
            if (dly_q == DW'(i + 1)) begin
                tap_dat = dat_q[i];
                tap_vld = vld_q[i];
            end
        end
    end

    assign ovld   = tap_vld & (st_q == RUN);
    assign odat   = ovld ? tap_dat : RSTVAL;
    assign settle = (st_q == SETTLE);

endmodule

// File: tb/tb_ffxkvar_dly.sv
// Scoreboard bench for ffxkvar_dly: stimulus pushes the samples that must
// emerge, a negedge monitor pops and compares them in order.
module tb_ffxkvar_dly;

    localparam int         WID  = 8;
    localparam int         DMAX = 16;
    localparam int         DW   = 5;
    localparam logic [7:0] RV   = 8'h5A;

    logic           clk = 1'b0;
    logic           rst;
    logic           ce;
    logic [DW-1:0]  dly;
    logic [WID-1:0] idat;
    logic           ivld;
    logic [WID-1:0] odat;
    logic           ovld;
    logic           settle;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q [$];
    logic        ce_e   = 1'b0;
    logic [7:0]  nxt    = 8'h00;

    always #5 clk = ~clk;

    ffxkvar_dly #(
        .WID    (WID),
        .DMAX   (DMAX),
        .DW     (DW),
        .RSTVAL (RV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .dly    (dly),
        .idat   (idat),
        .ivld   (ivld),
        .odat   (odat),
        .ovld   (ovld),
        .settle (settle)
    );

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got == want)
            n_pass++;
        else
            $display("FAIL %s: got %0d want %0d", nm, got, want);
    endtask

    // A new output word exists only after a ce-qualified edge.
    always @(posedge clk) ce_e <= ce;

    always @(negedge clk) begin
        if (ovld && ce_e) begin
            if (exp_q.size() == 0)
                chk("unexpected_out", int'(odat), -1);
            else
                chk("odat_order", int'(odat), int'(exp_q.pop_front()));
        end else if (!ovld) begin
            chk("odat_idle", int'(odat), int'(RV));
        end
    end

    task automatic step(input logic [7:0] d, input logic v,
                        input logic c, input bit fl);
        idat = d;
        ivld = v;
        ce   = c;
        @(posedge clk);
        #1;
        if (c && v)
            exp_q.push_back(d);
        if (fl)
            exp_q.delete();
    endtask

    task automatic go(input bit fl);
        step(nxt, 1'b1, 1'b1, fl);
        nxt++;
    endtask

    task automatic ramp(input int n);
        repeat (n) go(1'b0);
    endtask

    // Change delay at the next edge, then expect exactly d settle edges
    // ending with the first post-change sample at the tap.
    task automatic retarget(input logic [DW-1:0] nd, input int d,
                            input string nm);
        logic [7:0] first;
        dly = nd;
        go(1'b1);
        chk({nm, "_s0"}, int'(settle), 1);
        first = nxt;
        for (int k = 1; k <= d; k++) begin
            go(1'b0);
            chk({nm, "_settle"}, int'(settle), int'(k < d));
            chk({nm, "_ovld"}, int'(ovld), int'(k == d));
        end
        chk({nm, "_first"}, int'(odat), int'(first));
    endtask

    initial begin
        rst  = 1'b1;
        ce   = 1'b1;
        dly  = 5'd3;
        ivld = 1'b0;
        idat = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_odat", int'(odat), int'(RV));
        chk("rst_ovld", int'(ovld), 0);
        chk("rst_settle", int'(settle), 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: reset leaves dly_q=1, so dly=3 retargets on the first edge
        retarget(5'd3, 3, "t1");
        ramp(4);
        chk("t1_lat", int'(odat), int'(8'(nxt - 8'd3)));
        step(8'hEE, 1'b0, 1'b1, 1'b0);
        ramp(6);

        // T2: clamp low and high
        retarget(5'd0, 1, "t2lo");
        ramp(5);
        chk("t2lo_lat", int'(odat), int'(8'(nxt - 8'd1)));
        retarget(5'd31, 16, "t2hi");
        ramp(5);
        chk("t2hi_lat", int'(odat), int'(8'(nxt - 8'd16)));

        // T3: increase 4 -> 8
        retarget(5'd4, 4, "t3a");
        ramp(6);
        retarget(5'd8, 8, "t3");
        ramp(3);

        // T4: decrease 8 -> 2 with ce toggling
        begin
            logic [7:0] first;
            dly = 5'd2;
            go(1'b1);
            chk("t4_s0", int'(settle), 1);
            step(nxt, 1'b1, 1'b0, 1'b0);
            chk("t4_s1", int'(settle), 1);
            first = nxt;
            go(1'b0);
            chk("t4_s2", int'(settle), 1);
            step(nxt, 1'b1, 1'b0, 1'b0);
            chk("t4_s3", int'(settle), 1);
            go(1'b0);
            chk("t4_s4", int'(settle), 0);
            chk("t4_ovld", int'(ovld), 1);
            chk("t4_first", int'(odat), int'(first));
            for (int i = 0; i < 8; i++) begin
                if (i[0])
                    step(nxt, 1'b1, 1'b0, 1'b0);
                else
                    go(1'b0);
            end
        end

        // T5: 4 -> 6, then 6 -> 10 two edges later
        retarget(5'd4, 4, "t5a");
        ramp(4);
        dly = 5'd6;
        go(1'b1);
        chk("t5_mid_settle", int'(settle), 1);
        go(1'b0);
        retarget(5'd10, 10, "t5");
        ramp(3);

        // T6: one-clock reset mid-stream at D=1
        retarget(5'd1, 1, "t6a");
        ramp(5);
        rst = 1'b1;
        #1;
        chk("t6_odat", int'(odat), int'(RV));
        chk("t6_ovld", int'(ovld), 0);
        chk("t6_settle", int'(settle), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("t6_settle_rst", int'(settle), 0);
        rst = 1'b0;
        go(1'b0);
        chk("t6_ret_ovld", int'(ovld), 1);
        chk("t6_ret_settle", int'(settle), 0);
        chk("t6_ret_odat", int'(odat), int'(8'(nxt - 8'd1)));
        ramp(4);

        // Drain the line with invalid samples
        repeat (DMAX + 2) step(8'h00, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
